// File: rtl/io_pkg.sv
// Shared types and sizing helper for the operand/result I/O controller.
package io_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } io_state_t;

    // $clog2 with a floor of 1 so degenerate parameters still give a real vector.
    function automatic int CNT_W(input int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Result FIFO: pointer-based, push accepted on full only alongside a pop.
module io_fifo
    import io_pkg::*;
#(
    parameter int N         = 8,
    parameter int OUT_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = CNT_W(OUT_DEPTH);
    localparam int CW = CNT_W(OUT_DEPTH + 1);

    logic [N-1:0]  r_mem [OUT_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == CW'(OUT_DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= (r_wr_ptr == AW'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= (r_rd_ptr == AW'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/io_ctrl.sv
// Operand/result I/O controller between board switches/button and the CPU.
//   state | meaning
//   LOAD  | CPU halted, button presses latch switch operands
//   RUN   | CPU runs on operands, results queued; halted while FIFO full
//   DRAIN | CPU halted, button presses step display until all results shown
module io_ctrl
    import io_pkg::*;
#(
    parameter int N         = 8,
    parameter int N_IN      = 2,
    parameter int N_OUT     = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     handshake,
    input  logic [N-1:0]             in,
    input  logic                     cpu_rd,
    input  logic [N-1:0]             cpu_out,
    input  logic                     write_out,
    output logic [N-1:0]             cpu_in,
    output logic [N-1:0]             out,
    output logic                     out_valid,
    output logic                     halt_program,
    output logic [CNT_W(N_IN)-1:0]   in_idx,
    output logic                     overflow
);

    localparam int IW = CNT_W(N_IN);
    localparam int OW = CNT_W(N_OUT + 1);

    io_state_t     r_state;
    io_state_t     w_next;
    logic          r_hs_s1;
    logic          r_hs_s2;
    logic          r_hs_d;
    logic          w_hs_edge;
    logic [N-1:0]  r_ops [N_IN];
    logic [IW-1:0] r_in_idx;
    logic [IW-1:0] r_rd_ptr;
    logic [OW-1:0] r_wr_cnt;
    logic [OW-1:0] r_pop_cnt;
    logic          r_overflow;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_load_last;
    logic          w_halt;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [N-1:0]  w_fifo_head;

    assign w_hs_edge   = r_hs_s2 & ~r_hs_d;
    assign w_push      = write_out & (r_state == RUN);
    assign w_pop       = w_hs_edge & (r_state != LOAD) & ~w_fifo_empty;
    assign w_push_ok   = w_push & (~w_fifo_full | w_pop);
    assign w_load_last = (r_state == LOAD) & w_hs_edge & (r_in_idx == IW'(N_IN - 1));

    io_fifo #(
        .N         (N),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (cpu_out),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= LOAD;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_halt = 1'b1;
        case (r_state)
            LOAD: begin
                if (w_load_last)
                    w_next = RUN;
            end
            RUN: begin
                w_halt = w_fifo_full;
                if (w_push_ok && (r_wr_cnt == OW'(N_OUT - 1)))
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (w_fifo_empty && (r_pop_cnt == OW'(N_OUT)))
                    w_next = LOAD;
            end
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hs_s1    <= 1'b0;
            r_hs_s2    <= 1'b0;
            r_hs_d     <= 1'b0;
            r_in_idx   <= '0;
            r_rd_ptr   <= '0;
            r_wr_cnt   <= '0;
            r_pop_cnt  <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < N_IN; i++)
                r_ops[i] <= '0;
        end else begin
            r_hs_s1 <= handshake;
            r_hs_s2 <= r_hs_s1;
            r_hs_d  <= r_hs_s2;
            if ((r_state == LOAD) && w_hs_edge) begin
                r_ops[r_in_idx] <= in;
                r_in_idx        <= w_load_last ? '0 : r_in_idx + 1'b1;
            end
            if ((r_state == RUN) && cpu_rd)
                r_rd_ptr <= (r_rd_ptr == IW'(N_IN - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push_ok)
                r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_pop)
                r_pop_cnt <= r_pop_cnt + 1'b1;
            if (w_push && !w_push_ok)
                r_overflow <= 1'b1;
            // Transaction complete: rewind for the next operand set.
            if ((r_state == DRAIN) && (w_next == LOAD)) begin
                r_rd_ptr  <= '0;
                r_wr_cnt  <= '0;
                r_pop_cnt <= '0;
            end
        end
    end

    assign cpu_in       = r_ops[r_rd_ptr];
    assign out          = w_fifo_empty ? '0 : w_fifo_head;
    assign out_valid    = ~w_fifo_empty;
    assign halt_program = w_halt;
    assign in_idx       = r_in_idx;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_io_ctrl.sv
// Scoreboard bench for io_ctrl: instance a uses N_OUT=2, instance b N_OUT=3.
module tb_io_ctrl;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hs = 1'b0;
    logic       sel = 1'b0;
    logic       cpu_rd_v = 1'b0;
    logic       wo = 1'b0;
    logic [7:0] in_v = 8'h00;
    logic [7:0] cpu_out_v = 8'h00;

    logic       a_hs, a_rd, a_wo, b_hs, b_rd, b_wo;
    logic [7:0] a_cpu_in, a_out, b_cpu_in, b_out;
    logic       a_ov, a_halt, a_idx, a_ovf, b_ov, b_halt, b_idx, b_ovf;
    logic [7:0] m_cpu_in, m_out;
    logic       m_ov, m_halt, m_idx, m_ovf;

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] exp_q [$];

    assign a_hs = hs & ~sel;
    assign a_rd = cpu_rd_v & ~sel;
    assign a_wo = wo & ~sel;
    assign b_hs = hs & sel;
    assign b_rd = cpu_rd_v & sel;
    assign b_wo = wo & sel;

    assign m_cpu_in = sel ? b_cpu_in : a_cpu_in;
    assign m_out    = sel ? b_out    : a_out;
    assign m_ov     = sel ? b_ov     : a_ov;
    assign m_halt   = sel ? b_halt   : a_halt;
    assign m_idx    = sel ? b_idx    : a_idx;
    assign m_ovf    = sel ? b_ovf    : a_ovf;

    always #5 clk = ~clk;

    io_ctrl #(.N(8), .N_IN(2), .N_OUT(2), .OUT_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .handshake(a_hs), .in(in_v), .cpu_rd(a_rd),
        .cpu_out(cpu_out_v), .write_out(a_wo), .cpu_in(a_cpu_in), .out(a_out),
        .out_valid(a_ov), .halt_program(a_halt), .in_idx(a_idx), .overflow(a_ovf)
    );

    io_ctrl #(.N(8), .N_IN(2), .N_OUT(3), .OUT_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .handshake(b_hs), .in(in_v), .cpu_rd(b_rd),
        .cpu_out(cpu_out_v), .write_out(b_wo), .cpu_in(b_cpu_in), .out(b_out),
        .out_valid(b_ov), .halt_program(b_halt), .in_idx(b_idx), .overflow(b_ovf)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Action lands on the third edge after the press; release long enough to re-arm.
    task automatic press();
        hs = 1'b1;
        tick(3);
        hs = 1'b0;
        tick(3);
    endtask

    task automatic wr(input logic [7:0] v);
        cpu_out_v = v;
        wo = 1'b1;
        tick(1);
        wo = 1'b0;
        if (exp_q.size() < DEPTH)
            exp_q.push_back(v);
    endtask

    task automatic rd();
        cpu_rd_v = 1'b1;
        tick(1);
        cpu_rd_v = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hs = 1'b0;
        wo = 1'b0;
        cpu_rd_v = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        exp_q.delete();
    endtask

    task automatic load2(input logic [7:0] x, input logic [7:0] y);
        in_v = x;
        press();
        in_v = y;
        press();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        nvec++; if (m_out !== 8'h00) begin nmis++; $display("FAIL reset_out got %h exp 00", m_out); end
        nvec++; if (m_cpu_in !== 8'h00) begin nmis++; $display("FAIL reset_cpu_in got %h exp 00", m_cpu_in); end
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL reset_out_valid got %b exp 0", m_ov); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL reset_halt got %b exp 1", m_halt); end
        nvec++; if (m_idx !== 1'b0) begin nmis++; $display("FAIL reset_in_idx got %b exp 0", m_idx); end
        nvec++; if (m_ovf !== 1'b0) begin nmis++; $display("FAIL reset_overflow got %b exp 0", m_ovf); end
    endtask

    task automatic test_long_press();
        in_v = 8'h5A;
        hs = 1'b1;
        tick(10);
        hs = 1'b0;
        tick(3);
        nvec++; if (m_idx !== 1'b1) begin nmis++; $display("FAIL long_press_idx got %b exp 1", m_idx); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL long_press_halt got %b exp 1", m_halt); end
        do_reset();
    endtask

    task automatic test_load();
        in_v = 8'h2B;
        press();
        nvec++; if (m_idx !== 1'b1) begin nmis++; $display("FAIL load_idx1 got %b exp 1", m_idx); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL load_halt1 got %b exp 1", m_halt); end
        in_v = 8'h04;
        press();
        nvec++; if (m_idx !== 1'b0) begin nmis++; $display("FAIL load_idx2 got %b exp 0", m_idx); end
        nvec++; if (m_halt !== 1'b0) begin nmis++; $display("FAIL load_halt2 got %b exp 0", m_halt); end
        nvec++; if (m_cpu_in !== 8'h2B) begin nmis++; $display("FAIL load_op0 got %h exp 2b", m_cpu_in); end
        rd();
        nvec++; if (m_cpu_in !== 8'h04) begin nmis++; $display("FAIL load_op1 got %h exp 04", m_cpu_in); end
        rd();
        nvec++; if (m_cpu_in !== 8'h2B) begin nmis++; $display("FAIL load_wrap got %h exp 2b", m_cpu_in); end
    endtask

    task automatic test_empty_pop();
        press();
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL empty_pop_valid got %b exp 0", m_ov); end
        nvec++; if (m_halt !== 1'b0) begin nmis++; $display("FAIL empty_pop_halt got %b exp 0", m_halt); end
    endtask

    task automatic test_results();
        wr(8'hCC);
        nvec++; if (m_ov !== 1'b1) begin nmis++; $display("FAIL res_valid got %b exp 1", m_ov); end
        nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL res_head1 got %h exp %h", m_out, exp_q[0]); end
        nvec++; if (m_halt !== 1'b0) begin nmis++; $display("FAIL res_halt1 got %b exp 0", m_halt); end
        wr(8'hEE);
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL res_halt2 got %b exp 1", m_halt); end
        nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL res_head2 got %h exp %h", m_out, exp_q[0]); end
        press();
        void'(exp_q.pop_front());
        nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL res_head3 got %h exp %h", m_out, exp_q[0]); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL res_drain_halt got %b exp 1", m_halt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        nvec++; if (m_out !== 8'h00) begin nmis++; $display("FAIL mid_out got %h exp 00", m_out); end
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL mid_valid got %b exp 0", m_ov); end
        nvec++; if (m_cpu_in !== 8'h00) begin nmis++; $display("FAIL mid_cpu_in got %h exp 00", m_cpu_in); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL mid_halt got %b exp 1", m_halt); end
        nvec++; if (m_idx !== 1'b0) begin nmis++; $display("FAIL mid_idx got %b exp 0", m_idx); end
        load2(8'h01, 8'h02);
        nvec++; if (m_halt !== 1'b0) begin nmis++; $display("FAIL fresh_halt got %b exp 0", m_halt); end
        nvec++; if (m_cpu_in !== 8'h01) begin nmis++; $display("FAIL fresh_op0 got %h exp 01", m_cpu_in); end
        rd();
        nvec++; if (m_cpu_in !== 8'h02) begin nmis++; $display("FAIL fresh_op1 got %h exp 02", m_cpu_in); end
        wr(8'hA5);
        wr(8'h5A);
        for (int i = 0; i < 2; i++) begin
            nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL fresh_head%0d got %h exp %h", i, m_out, exp_q[0]); end
            press();
            void'(exp_q.pop_front());
        end
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL done_valid got %b exp 0", m_ov); end
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL done_halt got %b exp 1", m_halt); end
        in_v = 8'h33;
        press();
        nvec++; if (m_idx !== 1'b1) begin nmis++; $display("FAIL back_to_load_idx got %b exp 1", m_idx); end
    endtask

    task automatic test_ignored();
        cpu_out_v = 8'h77;
        wo = 1'b1;
        tick(1);
        wo = 1'b0;
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL ign_valid got %b exp 0", m_ov); end
        nvec++; if (m_ovf !== 1'b0) begin nmis++; $display("FAIL ign_overflow got %b exp 0", m_ovf); end
    endtask

    task automatic test_full();
        sel = 1'b1;
        do_reset();
        load2(8'h01, 8'h02);
        nvec++; if (m_halt !== 1'b0) begin nmis++; $display("FAIL full_run_halt got %b exp 0", m_halt); end
        wr(8'h11);
        wr(8'h22);
        nvec++; if (m_halt !== 1'b1) begin nmis++; $display("FAIL full_halt got %b exp 1", m_halt); end
        wr(8'h33);
        nvec++; if (m_ovf !== 1'b1) begin nmis++; $display("FAIL full_overflow got %b exp 1", m_ovf); end
        nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL full_head got %h exp %h", m_out, exp_q[0]); end
        // Pop and push land on the same edge.
        hs = 1'b1;
        tick(2);
        cpu_out_v = 8'h44;
        wo = 1'b1;
        tick(1);
        wo = 1'b0;
        hs = 1'b0;
        tick(3);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h44);
        for (int i = 0; i < 2; i++) begin
            nvec++; if (m_out !== exp_q[0]) begin nmis++; $display("FAIL full_disp%0d got %h exp %h", i, m_out, exp_q[0]); end
            press();
            void'(exp_q.pop_front());
        end
        nvec++; if (m_ov !== 1'b0) begin nmis++; $display("FAIL full_empty got %b exp 0", m_ov); end
        nvec++; if (m_ovf !== 1'b1) begin nmis++; $display("FAIL full_sticky got %b exp 1", m_ovf); end
        in_v = 8'h09;
        press();
        nvec++; if (m_idx !== 1'b1) begin nmis++; $display("FAIL full_load_idx got %b exp 1", m_idx); end
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_load();
        test_empty_pop();
        test_results();
        test_reset_mid();
        test_ignored();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
